// File: rtl/stereo_cfg_pkg.sv
// -----------------------------------------------------------------------------
// stereo_cfg_pkg
// Shared definitions for the stereo/NR3D configuration path: the bridge FSM
// state encoding, AXI response codes, grant encoding for the write/read
// arbiter, and the register map of the stereo APB register slave (also used by
// the testbench's slave model).
// -----------------------------------------------------------------------------
package stereo_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Which request type was served most recently.
    typedef enum logic {
        GRANT_RD = 1'b0,
        GRANT_WR = 1'b1
    } grant_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Register map, word-aligned, 0x260..0x288.
    localparam logic [11:0] REG_STEREO_DIM    = 12'h260;
    localparam logic [11:0] REG_STEREO_CTRL   = 12'h264;
    localparam logic [11:0] REG_NR3D_CTRL     = 12'h268;
    localparam logic [11:0] REG_NR3D_STRENGTH = 12'h26C;
    localparam logic [11:0] REG_NR3D_THRESH   = 12'h270;
    localparam logic [11:0] REG_DISP_RANGE    = 12'h274;
    localparam logic [11:0] REG_DISP_OFFSET   = 12'h278;
    localparam logic [11:0] REG_CONF_THRESH   = 12'h27C;
    localparam logic [11:0] REG_LR_CHECK      = 12'h280;
    localparam logic [11:0] REG_STATUS        = 12'h284;
    localparam logic [11:0] REG_IRQ_MASK      = 12'h288;

    // Frame dimensions reset value: height 1080 in [21:11], width 1920 in [10:0].
    localparam logic [31:0] STEREO_DIM_RST = 32'h0021_C780;

    // Word alignment test on the two address LSBs.
    function automatic logic is_aligned(input logic [1:0] lsb);
        return (lsb == 2'b00);
    endfunction

endpackage

// File: rtl/axi_lite_apb_bridge.sv
// -----------------------------------------------------------------------------
// axi_lite_apb_bridge
// AXI4-Lite (single beat, full-word) to APB bridge, zero wait states, one
// transfer in flight. Write and read requests are arbitrated round-robin via a
// 1-bit last-grant flop. Misaligned addresses are answered with SLVERR without
// touching the APB bus. Every output is a flop.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   s_aw*/s_w*/s_b*                 AXI-Lite write address / data / response
//   s_ar*/s_r*                      AXI-Lite read address / data
//   p_sel, p_enable, p_addr,
//   p_write, p_wr_data              APB master outputs
//   p_rd_data                       APB read data (valid in ACCESS)
// -----------------------------------------------------------------------------
module axi_lite_apb_bridge
    import stereo_cfg_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [ADDR_W-1:0] s_awaddr,
    input  logic              s_wvalid,
    output logic              s_wready,
    input  logic [DATA_W-1:0] s_wdata,
    output logic              s_bvalid,
    input  logic              s_bready,
    output logic [1:0]        s_bresp,
    input  logic              s_arvalid,
    output logic              s_arready,
    input  logic [ADDR_W-1:0] s_araddr,
    output logic              s_rvalid,
    input  logic              s_rready,
    output logic [DATA_W-1:0] s_rdata,
    output logic [1:0]        s_rresp,
    output logic              p_sel,
    output logic              p_enable,
    output logic [ADDR_W-1:0] p_addr,
    output logic              p_write,
    output logic [DATA_W-1:0] p_wr_data,
    input  logic [DATA_W-1:0] p_rd_data
);

    state_t state_q, state_d;
    grant_t last_grant_q, last_grant_d;
    logic   is_wr_q, is_wr_d;

    // AW and W share one ready flop so they are always accepted together.
    logic wr_rdy_q, wr_rdy_d;
    logic arready_d;
    logic bvalid_d, rvalid_d;
    logic [1:0] bresp_d, rresp_d;
    logic [DATA_W-1:0] rdata_d, wr_data_d;
    logic sel_d, en_d, write_d;
    logic [ADDR_W-1:0] addr_d;

    logic wr_req, rd_req, acc_wr, acc_rd, acc_aligned;

    assign s_awready = wr_rdy_q;
    assign s_wready  = wr_rdy_q;

    assign wr_req = s_awvalid & s_wvalid;
    assign rd_req = s_arvalid;
    // Readies are only ever high in IDLE, so a handshake implies IDLE.
    assign acc_wr = wr_rdy_q & wr_req;
    assign acc_rd = s_arready & rd_req;
    assign acc_aligned = acc_wr ? is_aligned(s_awaddr[1:0]) : is_aligned(s_araddr[1:0]);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (acc_wr || acc_rd) state_d = acc_aligned ? SETUP : RESP;
            SETUP:   state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    if ((s_bvalid && s_bready) || (s_rvalid && s_rready)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs.
    always_comb begin
        wr_rdy_d     = 1'b0;
        arready_d    = 1'b0;
        sel_d        = 1'b0;
        en_d         = 1'b0;
        addr_d       = p_addr;
        write_d      = p_write;
        wr_data_d    = p_wr_data;
        bvalid_d     = s_bvalid & ~s_bready;
        rvalid_d     = s_rvalid & ~s_rready;
        bresp_d      = s_bresp;
        rresp_d      = s_rresp;
        rdata_d      = s_rdata;
        is_wr_d      = is_wr_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (acc_wr) begin
                    is_wr_d      = 1'b1;
                    last_grant_d = GRANT_WR;
                    if (acc_aligned) begin
                        sel_d     = 1'b1;
                        addr_d    = s_awaddr;
                        write_d   = 1'b1;
                        wr_data_d = s_wdata;
                    end else begin
                        bvalid_d = 1'b1;
                        bresp_d  = RESP_SLVERR;
                    end
                end else if (acc_rd) begin
                    is_wr_d      = 1'b0;
                    last_grant_d = GRANT_RD;
                    if (acc_aligned) begin
                        sel_d     = 1'b1;
                        addr_d    = s_araddr;
                        write_d   = 1'b0;
                        wr_data_d = '0;
                    end else begin
                        rvalid_d = 1'b1;
                        rresp_d  = RESP_SLVERR;
                        rdata_d  = '0;
                    end
                end else if (!wr_rdy_q && !s_arready) begin
                    // Ready is raised one cycle after the request is seen, which
                    // also yields the turnaround cycle after RESP.
                    if (wr_req && (!rd_req || last_grant_q == GRANT_RD)) wr_rdy_d = 1'b1;
                    else if (rd_req)                                     arready_d = 1'b1;
                end
            end
            SETUP: begin
                sel_d = 1'b1;
                en_d  = 1'b1;
            end
            ACCESS: begin
                if (is_wr_q) begin
                    bvalid_d = 1'b1;
                    bresp_d  = RESP_OKAY;
                end else begin
                    rvalid_d = 1'b1;
                    rresp_d  = RESP_OKAY;
                    rdata_d  = p_rd_data;
                end
            end
            default: ;
        endcase
    end

    // Output and bookkeeping registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_rdy_q     <= 1'b0;
            s_arready    <= 1'b0;
            s_bvalid     <= 1'b0;
            s_bresp      <= RESP_OKAY;
            s_rvalid     <= 1'b0;
            s_rdata      <= '0;
            s_rresp      <= RESP_OKAY;
            p_sel        <= 1'b0;
            p_enable     <= 1'b0;
            p_addr       <= '0;
            p_write      <= 1'b0;
            p_wr_data    <= '0;
            is_wr_q      <= 1'b0;
            last_grant_q <= GRANT_RD;
        end else begin
            wr_rdy_q     <= wr_rdy_d;
            s_arready    <= arready_d;
            s_bvalid     <= bvalid_d;
            s_bresp      <= bresp_d;
            s_rvalid     <= rvalid_d;
            s_rdata      <= rdata_d;
            s_rresp      <= rresp_d;
            p_sel        <= sel_d;
            p_enable     <= en_d;
            p_addr       <= addr_d;
            p_write      <= write_d;
            p_wr_data    <= wr_data_d;
            is_wr_q      <= is_wr_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule
